// File: rtl/seg_pkg.sv
// Shared 7-segment constants: segment bit positions, blank pattern and hex glyph table.
// Glyphs are active-high {g,f,e,d,c,b,a}; drivers invert them for the pins.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph lookup, active-high {g..a}.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = HEX_GLYPH[nibble_i];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver with its own scan counters, double-buffered
// display data committed at frame boundaries, and leading anode dead-time per slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [8*DIGITS-1:0]   raw,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     blank,
  output logic                  pending,
  output logic                  frame_done,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_C   = PW'(DEAD);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [DW-1:0] digit_q, digit_d;
  logic          pending_q, pending_d;
  logic [7:0]    seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic                pend_mode_q, shad_mode_q;
  logic [4*DIGITS-1:0] pend_hexs_q, shad_hexs_q;
  logic [8*DIGITS-1:0] pend_raw_q,  shad_raw_q;
  logic [DIGITS-1:0]   pend_point_q, shad_point_q;
  logic [DIGITS-1:0]   pend_blank_q, shad_blank_q;

  logic tick, frame_end, commit;
  logic [3:0] nib_arr [DIGITS];
  logic [7:0] raw_arr [DIGITS];
  logic [3:0] cur_nib;
  logic [7:0] cur_raw;
  logic [6:0] cur_glyph;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slice
      assign nib_arr[gi] = shad_hexs_q[4*gi +: 4];
      assign raw_arr[gi] = shad_raw_q[8*gi +: 8];
    end
  endgenerate

  assign cur_nib = nib_arr[digit_q];
  assign cur_raw = raw_arr[digit_q];

  seg_hex_decode u_dec (
    .nibble_i (cur_nib),
    .glyph_o  (cur_glyph)
  );

  always_comb begin
    tick        = (prescaler_q == PRE_LAST);
    frame_end   = tick && (digit_q == DIG_LAST);
    commit      = frame_end && pending_q;
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    digit_d     = digit_q;
    if (tick) digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    // A load coinciding with the commit re-arms pending for the next frame.
    pending_d   = load | (pending_q & ~frame_end);
  end

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = '1;
    if ((prescaler_q >= DEAD_C) && !shad_blank_q[digit_q]) begin
      an_d  = ~(DIGITS'(1) << digit_q);
      seg_d = shad_mode_q ? ~cur_raw : ~{shad_point_q[digit_q], cur_glyph};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prescaler_q  <= '0;
      digit_q      <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
      pend_mode_q  <= 1'b0;
      pend_hexs_q  <= '0;
      pend_raw_q   <= '0;
      pend_point_q <= '0;
      pend_blank_q <= '1;
      shad_mode_q  <= 1'b0;
      shad_hexs_q  <= '0;
      shad_raw_q   <= '0;
      shad_point_q <= '0;
      shad_blank_q <= '1;
    end else begin
      prescaler_q <= prescaler_d;
      digit_q     <= digit_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      if (load) begin
        pend_mode_q  <= mode;
        pend_hexs_q  <= hexs;
        pend_raw_q   <= raw;
        pend_point_q <= point;
        pend_blank_q <= blank;
      end
      if (commit) begin
        shad_mode_q  <= pend_mode_q;
        shad_hexs_q  <= pend_hexs_q;
        shad_raw_q   <= pend_raw_q;
        shad_point_q <= pend_point_q;
        shad_blank_q <= pend_blank_q;
      end
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_end;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: a cycle-count reference model predicts seg/an/pending/frame_done.
module tb_seg_scan_driver;

  localparam int D  = 4;
  localparam int S  = 4;
  localparam int DT = 1;
  localparam int FR = D * S;

  logic        clk, rstn, load, mode;
  logic [15:0] hexs;
  logic [31:0] raw;
  logic [3:0]  point, blank;
  logic        pending, frame_done;
  logic [7:0]  seg;
  logic [3:0]  an;

  seg_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .DEAD(DT)) dut (
    .clk(clk), .rstn(rstn), .load(load), .mode(mode), .hexs(hexs), .raw(raw),
    .point(point), .blank(blank), .pending(pending), .frame_done(frame_done),
    .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [15:0] hexs;
    logic [31:0] raw;
    logic [3:0]  point;
    logic [3:0]  blank;
  } buf_t;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] an;
    logic       pend;
    logic       fd;
  } exp_t;

  logic [6:0] glyph_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  exp_t sb_q[$];
  buf_t m_shadow, m_pbuf, dark;
  bit   m_pend;
  int   m_t;
  exp_t m_e, mon_e;
  int   tests = 0;
  int   fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (model t=%0d, time %0t)", name, act, exp, m_t, $time);
    end
  endfunction

  // Expected pins for a given time since reset: slot = t/S, position in slot = t%S.
  function automatic void view(input buf_t b, input int t, output logic [7:0] s, output logic [3:0] a);
    int pos, d;
    pos = t % S;
    d   = (t / S) % D;
    s = 8'hFF;
    a = 4'hF;
    if (pos >= DT && !b.blank[d]) begin
      a[d] = 1'b0;
      if (b.mode) s = ~b.raw[8*d +: 8];
      else        s = ~{b.point[d], glyph_tab[b.hexs[4*d +: 4]]};
    end
  endfunction

  initial begin
    dark = '{mode: 1'b0, hexs: 16'h0, raw: 32'h0, point: 4'h0, blank: 4'hF};
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_t = 0; m_shadow = dark; m_pbuf = dark; m_pend = 0;
    end else begin
      view(m_shadow, m_t, m_e.seg, m_e.an);
      if ((m_t % FR) == FR - 1) begin
        if (m_pend) m_shadow = m_pbuf;
        m_pend = 0;
      end
      if (load) begin
        m_pbuf = '{mode: mode, hexs: hexs, raw: raw, point: point, blank: blank};
        m_pend = 1;
      end
      m_t++;
      m_e.pend = m_pend;
      m_e.fd   = ((m_t % FR) == FR - 1);
      sb_q.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    if (!rstn) sb_q.delete();
    else if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("seg", {24'h0, seg}, {24'h0, mon_e.seg});
      chk("an", {28'h0, an}, {28'h0, mon_e.an});
      chk("pending", {31'h0, pending}, {31'h0, mon_e.pend});
      chk("frame_done", {31'h0, frame_done}, {31'h0, mon_e.fd});
    end
  end

  task automatic do_load(input logic md, input logic [15:0] h, input logic [31:0] r,
                         input logic [3:0] p, input logic [3:0] b);
    mode = md; hexs = h; raw = r; point = p; blank = b; load = 1'b1;
    $display("[TB] load mode=%0b hexs=%h raw=%h point=%b blank=%b at t=%0d", md, h, r, p, b, m_t);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while ((m_t % FR) != ph && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_phase_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; load = 1'b0; mode = 1'b0; hexs = '0; raw = '0; point = '0; blank = '0;
    repeat (3) @(negedge clk);
    chk("reset_seg", {24'h0, seg}, 32'hFF);
    chk("reset_an", {28'h0, an}, 32'hF);
    chk("reset_pending", {31'h0, pending}, 32'h0);
    chk("reset_frame_done", {31'h0, frame_done}, 32'h0);
    rstn = 1'b1;
    repeat (3 * FR) @(negedge clk);

    wait_phase(5);
    do_load(1'b0, 16'h3210, 32'h0, 4'b0100, 4'h0);
    repeat (2 * FR) @(negedge clk);

    do_load(1'b1, 16'h0, 32'hFF008001, 4'hF, 4'h0);
    repeat (2 * FR) @(negedge clk);

    wait_phase(4);
    do_load(1'b0, 16'h1111, 32'h0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    do_load(1'b0, 16'h2222, 32'h0, 4'h0, 4'h0);
    repeat (2 * FR) @(negedge clk);

    wait_phase(6);
    do_load(1'b0, 16'h4567, 32'h0, 4'h1, 4'h0);
    wait_phase(FR - 1);
    do_load(1'b0, 16'h89AB, 32'h0, 4'h8, 4'h0);
    repeat (2 * FR) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      do_load(1'($urandom), 16'($urandom), 32'($urandom), 4'($urandom),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end
    repeat (2 * FR) @(negedge clk);

    do_load(1'b0, 16'hC0DE, 32'h0, 4'h0, 4'h0);
    repeat (2 * FR) @(negedge clk);
    wait_phase(7);
    do_load(1'b0, 16'hBEEF, 32'h0, 4'h0, 4'h0);
    wait_phase(2 * S + 1);
    #2 rstn = 1'b0;
    #1;
    $display("[TB] async reset asserted mid-slot at digit 2");
    chk("async_rst_seg", {24'h0, seg}, 32'hFF);
    chk("async_rst_an", {28'h0, an}, 32'hF);
    chk("async_rst_pending", {31'h0, pending}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * FR) @(negedge clk);
    do_load(1'b0, 16'h7654, 32'h0, 4'h2, 4'h0);
    repeat (2 * FR) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
